// File: rtl/dec_seq_sel.sv
// Registered N-to-2^N one-hot select decoder with command handshake,
// programmable per-index dwell and an incrementing auto-scan mode.
module dec_seq_sel #(
   parameter int unsigned AW    = 4,
   parameter int unsigned DWELL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mode,
   input  logic [AW-1:0]     in_addr,
   output logic [2**AW-1:0]  y,
   output logic [AW-1:0]     idx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned NOUT = 2**AW;
   localparam int unsigned CW   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [AW-1:0]   idx_nxt;
   logic [AW-1:0]   last;
   logic [AW-1:0]   last_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [NOUT-1:0] y_nxt;
   logic            busy_nxt;
   logic            done_nxt;
   logic            accept;
   logic            expire;

   assign in_ready = (state == IDLE) & en & ~rst;
   assign accept   = in_valid & in_ready;
   // Dwell ends on the en-high cycle that sees the final count.
   assign expire   = en & (cnt == CW'(1));

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         last  <= '0;
         cnt   <= '0;
         y     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
         y     <= y_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state: command accept, dwell countdown and scan advance; en low freezes all
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      last_nxt  = last;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               cnt_nxt = CW'(DWELL);
               if (in_mode) begin
                  state_nxt = SCAN;
                  last_nxt  = in_addr;
                  idx_nxt   = '0;
               end else begin
                  state_nxt = DIRECT;
                  idx_nxt   = in_addr;
               end
            end
         end
         DIRECT: begin
            if (expire) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (en) begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         SCAN: begin
            if (expire) begin
               if (idx == last) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  idx_nxt = idx + AW'(1);
                  cnt_nxt = CW'(DWELL);
               end
            end else if (en) begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs for the next cycle, derived from the next state
   always_comb begin
      y_nxt    = '0;
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state != IDLE) && (state_nxt == IDLE);
      if (en && (state_nxt != IDLE)) begin
         y_nxt = NOUT'(1) << idx_nxt;
      end
   end

endmodule

// File: tb/tb_dec_seq_sel.sv
// Scoreboard bench for dec_seq_sel: three configurations share en/rst; one is
// active at a time and its outputs are compared against queued expectations.
module tb_dec_seq_sel;

   typedef struct packed {
      logic [15:0] y;
      logic [3:0]  idx;
      logic        busy;
      logic        done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic [2:0] vld = '0;
   logic       in_mode = 1'b0;
   logic [3:0] in_addr = 4'd5;

   logic [15:0] y0, y1;
   logic [7:0]  y2;
   logic [3:0]  idx0, idx1;
   logic [2:0]  idx2;
   logic        rdy0, rdy1, rdy2, busy0, busy1, busy2, done0, done1, done2;

   int   cur = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_acc = 0;
   logic tmo = 1'b0;

   exp_t        sbq[$];
   logic [15:0] yv;
   logic [3:0]  iv;
   logic        bv, dv, rv;

   always #5 clk = ~clk;

   dec_seq_sel #(.AW(4), .DWELL(2)) u_a4d2 (
      .clk(clk), .rst(rst), .en(en), .in_valid(vld[0]), .in_ready(rdy0),
      .in_mode(in_mode), .in_addr(in_addr), .y(y0), .idx(idx0), .busy(busy0), .done(done0));

   dec_seq_sel #(.AW(4), .DWELL(1)) u_a4d1 (
      .clk(clk), .rst(rst), .en(en), .in_valid(vld[1]), .in_ready(rdy1),
      .in_mode(in_mode), .in_addr(in_addr), .y(y1), .idx(idx1), .busy(busy1), .done(done1));

   dec_seq_sel #(.AW(3), .DWELL(1)) u_a3d1 (
      .clk(clk), .rst(rst), .en(en), .in_valid(vld[2]), .in_ready(rdy2),
      .in_mode(in_mode), .in_addr(in_addr[2:0]), .y(y2), .idx(idx2), .busy(busy2), .done(done2));

   always_comb begin
      case (cur)
         0:       begin yv = y0;       iv = idx0;      bv = busy0; dv = done0; rv = rdy0; end
         1:       begin yv = y1;       iv = idx1;      bv = busy1; dv = done1; rv = rdy1; end
         default: begin yv = 16'(y2);  iv = 4'(idx2);  bv = busy2; dv = done2; rv = rdy2; end
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (unit %0d, t=%0t)", tag, got, exp, cur, $time);
      end
   endtask

   // Expected output cycles of one command: each index for DWELL cycles, then the done cycle
   task automatic push_cmd(input logic m, input logic [3:0] a);
      exp_t e;
      int   dw;
      int   last_i;
      dw     = (cur == 0) ? 2 : 1;
      last_i = m ? int'(a) : 0;
      e      = '0;
      for (int i = 0; i <= last_i; i++) begin
         for (int d = 0; d < dw; d++) begin
            e.idx  = m ? 4'(i) : a;
            e.y    = 16'd1 << e.idx;
            e.busy = 1'b1;
            e.done = 1'b0;
            sbq.push_back(e);
         end
      end
      e.y    = '0;
      e.busy = 1'b0;
      e.done = 1'b1;
      sbq.push_back(e);
   endtask

   // Scoreboard: push on accepting edge, pop/compare mid-cycle; en-low edges consume nothing
   always begin : monitor
      logic       en_e;
      logic       rst_e;
      logic [3:0] hold_idx;
      int         prev_cur;
      exp_t       e;
      hold_idx = '0;
      prev_cur = 0;
      forever begin
         @(posedge clk);
         en_e  = en;
         rst_e = rst;
         if (rst) begin
            sbq.delete();
         end else if ((sbq.size() == 0) && en && vld[cur]) begin
            push_cmd(in_mode, in_addr);
            n_acc++;
         end
         @(negedge clk);
         if (cur != prev_cur) begin
            hold_idx = '0;
            prev_cur = cur;
         end
         if (rst_e) begin
            e        = '0;
            hold_idx = '0;
         end else if (en_e && (sbq.size() != 0)) begin
            e        = sbq.pop_front();
            hold_idx = e.idx;
         end else begin
            e      = '0;
            e.idx  = hold_idx;
            e.busy = (sbq.size() != 0);
         end
         chk("y", 32'(yv), 32'(e.y));
         chk("idx", 32'(iv), 32'(e.idx));
         chk("busy", 32'(bv), 32'(e.busy));
         chk("done", 32'(dv), 32'(e.done));
         chk("in_ready", 32'(rv), 32'(!e.busy && en && !rst));
         chk("timeout", 32'(tmo), 32'(0));
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cmd(input int u, input logic m, input logic [3:0] a);
      int start;
      start   = n_acc;
      in_mode = m;
      in_addr = a;
      vld[u]  = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (n_acc != start) break;
      end
      if (n_acc == start) tmo = 1'b1;
      vld[u] = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 600; i++) begin
         tick(1);
         if (sbq.size() == 0) break;
      end
      if (sbq.size() != 0) tmo = 1'b1;
   endtask

   initial begin
      // Reset held two cycles with a direct command (index 5) already valid
      vld[0] = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      vld[0] = 1'b0;
      wait_idle();

      // en low while idle: nothing accepted, in_ready low
      en      = 1'b0;
      in_addr = 4'd3;
      vld[0]  = 1'b1;
      tick(3);
      vld[0] = 1'b0;
      en     = 1'b1;
      tick(1);

      // valid held high while busy: next command only at the done cycle
      in_mode = 1'b0;
      in_addr = 4'd9;
      vld[0]  = 1'b1;
      tick(1);
      in_addr = 4'd12;
      tick(4);
      vld[0] = 1'b0;
      wait_idle();

      // pause of three cycles while scanning index 1
      cmd(0, 1'b1, 4'd3);
      tick(2);
      en = 1'b0;
      tick(3);
      en = 1'b1;
      wait_idle();
      cmd(0, 1'b1, 4'd15);
      wait_idle();
      tick(2);

      cur = 1;
      tick(1);
      cmd(1, 1'b1, 4'd3);
      wait_idle();
      cmd(1, 1'b1, 4'd0);
      wait_idle();
      cmd(1, 1'b1, 4'd15);
      wait_idle();
      // reset mid-scan aborts without done
      cmd(1, 1'b1, 4'd15);
      tick(5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(4);
      cmd(1, 1'b0, 4'd14);
      wait_idle();
      tick(2);

      cur = 2;
      tick(1);
      for (int a = 0; a < 8; a++) begin
         cmd(2, 1'b0, 4'(a));
         wait_idle();
      end
      cmd(2, 1'b1, 4'd7);
      wait_idle();
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
